ps2_keyboard: RTL and testbench

Receives a PS/2 keyboard serial stream and maintains a 40-key ZX Spectrum matrix image. It answers half-row reads with the active-low `kd[4:0]` consumed by port #FE decoding. It sits directly upstream of the I/O ports block, which feeds it `bus.a[15:8]` and samples `kd`. It also produces one-cycle reset and magic-button requests and, optionally, cursor-joystick data for the Kempston port.

---
 rtl/ps2_keyboard_pkg.sv | 120 ++++++++++++
 rtl/ps2_keyboard_rx.sv | 121 ++++++++++++
 rtl/ps2_keyboard.sv | 229 ++++++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_pkg.sv
// ps2_keyboard_pkg
//   Shared definitions for the PS/2 keyboard to ZX Spectrum matrix bridge:
//   decoder state enum, scan-code constants and the scan-code -> key-matrix
//   lookup used by ps2_keyboard.
//
//   Matrix bit numbering: bit (r*5 + c) is half-row r, column c, where
//   half-row r is the one selected by addr_hi[r] == 0.
//
//   Optional feature macro: PS2_KEMPSTON_EN. When defined, the cursor arrows
//   and Right Ctrl are removed from the matrix map and reported through
//   ps2_kempmap() instead.
package ps2_keyboard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_SKIP
  } ps2_state_t;

  localparam logic [7:0] PS2_E0  = 8'hE0;
  localparam logic [7:0] PS2_F0  = 8'hF0;
  localparam logic [7:0] PS2_E1  = 8'hE1;
  localparam logic [7:0] PS2_BAT = 8'hAA;

  // Bytes following E1 that belong to the Pause sequence (E1 14 77 E1 F0 14 F0 77).
  localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

  // One-hot mask for half-row r, column c.
  function automatic logic [39:0] kb(input int r, input int c);
    logic [39:0] one;
    one = 40'd1;
    return one << (r * 5 + c);
  endfunction

  // Returns the set of matrix keys driven by a scan code (set 2).
  function automatic logic [39:0] ps2_keymap(input logic ext, input logic [7:0] code);
    logic [39:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        8'h12, 8'h59: m = kb(0, 0);            // shifts -> CAPS SHIFT
        8'h1A: m = kb(0, 1);                   // Z
        8'h22: m = kb(0, 2);                   // X
        8'h21: m = kb(0, 3);                   // C
        8'h2A: m = kb(0, 4);                   // V
        8'h1C: m = kb(1, 0);                   // A
        8'h1B: m = kb(1, 1);                   // S
        8'h23: m = kb(1, 2);                   // D
        8'h2B: m = kb(1, 3);                   // F
        8'h34: m = kb(1, 4);                   // G
        8'h15: m = kb(2, 0);                   // Q
        8'h1D: m = kb(2, 1);                   // W
        8'h24: m = kb(2, 2);                   // E
        8'h2D: m = kb(2, 3);                   // R
        8'h2C: m = kb(2, 4);                   // T
        8'h16: m = kb(3, 0);                   // 1
        8'h1E: m = kb(3, 1);                   // 2
        8'h26: m = kb(3, 2);                   // 3
        8'h25: m = kb(3, 3);                   // 4
        8'h2E: m = kb(3, 4);                   // 5
        8'h45: m = kb(4, 0);                   // 0
        8'h46: m = kb(4, 1);                   // 9
        8'h3E: m = kb(4, 2);                   // 8
        8'h3D: m = kb(4, 3);                   // 7
        8'h36: m = kb(4, 4);                   // 6
        8'h4D: m = kb(5, 0);                   // P
        8'h44: m = kb(5, 1);                   // O
        8'h43: m = kb(5, 2);                   // I
        8'h3C: m = kb(5, 3);                   // U
        8'h35: m = kb(5, 4);                   // Y
        8'h5A: m = kb(6, 0);                   // ENTER
        8'h4B: m = kb(6, 1);                   // L
        8'h42: m = kb(6, 2);                   // K
        8'h3B: m = kb(6, 3);                   // J
        8'h33: m = kb(6, 4);                   // H
        8'h29: m = kb(7, 0);                   // SPACE
        8'h14: m = kb(7, 1);                   // Left Ctrl -> SYMBOL SHIFT
        8'h3A: m = kb(7, 2);                   // M
        8'h31: m = kb(7, 3);                   // N
        8'h32: m = kb(7, 4);                   // B
        8'h66: m = kb(0, 0) | kb(4, 0);        // Backspace -> CAPS+0
        default: m = '0;
      endcase
    end else begin
      case (code)
`ifndef PS2_KEMPSTON_EN
        8'h14: m = kb(7, 1);                   // Right Ctrl -> SYMBOL SHIFT
        8'h6B: m = kb(0, 0) | kb(3, 4);        // left  -> CAPS+5
        8'h74: m = kb(0, 0) | kb(4, 2);        // right -> CAPS+8
        8'h75: m = kb(0, 0) | kb(4, 3);        // up    -> CAPS+7
        8'h72: m = kb(0, 0) | kb(4, 4);        // down  -> CAPS+6
`endif
        default: m = '0;
      endcase
    end
    return m;
  endfunction

`ifdef PS2_KEMPSTON_EN
  // Kempston joystick bits: 0 right, 1 left, 2 down, 3 up, 4 fire.
  function automatic logic [4:0] ps2_kempmap(input logic ext, input logic [7:0] code);
    logic [4:0] j;
    j = '0;
    if (ext) begin
      case (code)
        8'h74: j = 5'b00001;
        8'h6B: j = 5'b00010;
        8'h72: j = 5'b00100;
        8'h75: j = 5'b01000;
        8'h14: j = 5'b10000;
        default: j = '0;
      endcase
    end
    return j;
  endfunction
`endif

endpackage

// File: rtl/ps2_keyboard_rx.sv
// ps2_rx
//   PS/2 device-to-host frame receiver. Synchronises the raw PS/2 lines,
//   samples one bit per falling clock edge, checks start/parity/stop and
//   abandons partial frames after TIMEOUT_CYCLES without a falling edge.
//
//   Ports
//     clk28     in   system clock
//     rst_n     in   asynchronous active-low reset
//     ps2_clk   in   raw PS/2 clock (asynchronous)
//     ps2_dat   in   raw PS/2 data  (asynchronous)
//     rx_valid  out  one-cycle strobe, rx_data holds a good byte
//     rx_data   out  received byte
//     rx_err    out  one-cycle strobe on a parity or stop-bit error
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [2:0]    dat_sync_q, dat_sync_d;
  // 0 = waiting for start bit, 1..8 = data bits, 9 = parity, 10 = stop
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_err_q, rx_err_d;

  logic fall;
  logic dat;

  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign dat  = dat_sync_q[2];

  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[1:0], ps2_dat};
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tcnt_d     = tcnt_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_err_d   = 1'b0;

    if (fall) begin
      tcnt_d = '0;
      case (bit_cnt_q)
        4'd0: begin
          // A high start bit is noise or a lost frame: stay idle.
          if (!dat) bit_cnt_d = 4'd1;
        end
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        4'd9: begin
          par_d     = dat;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (dat && (^{par_q, shift_q})) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
          end else begin
            rx_err_d = 1'b1;
          end
        end
        default: bit_cnt_d = 4'd0;
      endcase
    end else if (bit_cnt_q != 4'd0) begin
      if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 4'd0;
        tcnt_d    = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tcnt_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tcnt_q     <= tcnt_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard
//   PS/2 keyboard to ZX Spectrum 40-key matrix. Decodes make/break scan
//   codes into a key matrix and answers half-row reads with active-low kd.
//   Also raises one-cycle reset (Ctrl+Alt+Del) and magic (F11) requests.
//
//   Optional feature macro: PS2_KEMPSTON_EN -- cursor arrows and Right Ctrl
//   drive kempston_data instead of the matrix; the port exists only then.
//
//   Ports
//     clk28          in   28 MHz system clock
//     rst_n          in   asynchronous active-low reset
//     ps2_clk        in   raw PS/2 clock
//     ps2_dat        in   raw PS/2 data
//     addr_hi        in   CPU A[15:8]; a 0 bit selects that half-row
//     kd             out  active-low key columns (registered)
//     key_reset      out  one-cycle Ctrl+Alt+Del pulse
//     key_magic      out  one-cycle F11 make pulse
//     kempston_data  out  joystick bits (PS2_KEMPSTON_EN only)
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] addr_hi,
  output logic [4:0] kd,
  output logic       key_reset,
  output logic       key_magic
`ifdef PS2_KEMPSTON_EN
  ,
  output logic [7:0] kempston_data
`endif
);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk28   (clk28),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_err  (rx_err)
  );

  ps2_state_t  state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [39:0] matrix_q, matrix_d;
  logic        ctrl_q, ctrl_d;
  logic        alt_q, alt_d;
  logic        del_q, del_d;
  logic        key_reset_q, key_reset_d;
  logic        key_magic_q, key_magic_d;
  logic [4:0]  kd_q, kd_d;
`ifdef PS2_KEMPSTON_EN
  logic [4:0]  kemp_q, kemp_d;
`endif

  // Decoded event for the current byte
  logic        make_ev;
  logic        break_ev;
  logic        clear_ev;
  logic        ext_ev;
  logic [39:0] key_mask;
  logic        is_ctrl, is_alt, is_del;

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    make_ev     = 1'b0;
    break_ev    = 1'b0;
    clear_ev    = 1'b0;
    ext_ev      = 1'b0;

    if (rx_err) begin
      // A corrupted byte may have been a prefix; never apply it to the next code.
      state_d = ST_IDLE;
      skip_d  = '0;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == PS2_E0) begin
            state_d = ST_E0;
          end else if (rx_data == PS2_F0) begin
            state_d = ST_F0;
          end else if (rx_data == PS2_E1) begin
            state_d = ST_SKIP;
            skip_d  = PS2_PAUSE_TAIL;
          end else if (rx_data == PS2_BAT || rx_data == 8'h00 || rx_data == 8'hFF) begin
            clear_ev = 1'b1;
          end else begin
            make_ev = 1'b1;
          end
        end
        ST_E0: begin
          state_d = ST_IDLE;
          if (rx_data == PS2_F0) begin
            state_d = ST_E0F0;
          end else if (rx_data != 8'h12) begin
            // E0 12 is the fake shift some keyboards wrap around nav keys.
            make_ev = 1'b1;
            ext_ev  = 1'b1;
          end
        end
        ST_F0: begin
          state_d  = ST_IDLE;
          break_ev = 1'b1;
        end
        ST_E0F0: begin
          state_d  = ST_IDLE;
          break_ev = 1'b1;
          ext_ev   = 1'b1;
        end
        ST_SKIP: begin
          if (skip_q <= 3'd1) begin
            state_d = ST_IDLE;
            skip_d  = '0;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign key_mask = ps2_keymap(ext_ev, rx_data);
  assign is_ctrl  = (rx_data == 8'h14);
  assign is_alt   = (rx_data == 8'h11);
  assign is_del   = ext_ev && (rx_data == 8'h71);

  always_comb begin
    matrix_d    = matrix_q;
    ctrl_d      = ctrl_q;
    alt_d       = alt_q;
    del_d       = del_q;
    key_reset_d = 1'b0;
    key_magic_d = 1'b0;
`ifdef PS2_KEMPSTON_EN
    kemp_d      = kemp_q;
`endif

    if (clear_ev) begin
      matrix_d = '0;
      ctrl_d   = 1'b0;
      alt_d    = 1'b0;
      del_d    = 1'b0;
`ifdef PS2_KEMPSTON_EN
      kemp_d   = '0;
`endif
    end else if (make_ev) begin
      matrix_d    = matrix_q | key_mask;
      ctrl_d      = ctrl_q | is_ctrl;
      alt_d       = alt_q  | is_alt;
      del_d       = del_q  | is_del;
      key_reset_d = is_del && ctrl_q && alt_q;
      key_magic_d = !ext_ev && (rx_data == 8'h78);
`ifdef PS2_KEMPSTON_EN
      kemp_d      = kemp_q | ps2_kempmap(ext_ev, rx_data);
`endif
    end else if (break_ev) begin
      matrix_d = matrix_q & ~key_mask;
      ctrl_d   = ctrl_q & ~is_ctrl;
      alt_d    = alt_q  & ~is_alt;
      del_d    = del_q  & ~is_del;
`ifdef PS2_KEMPSTON_EN
      kemp_d   = kemp_q & ~ps2_kempmap(ext_ev, rx_data);
`endif
    end
  end

  // Column c reads low when any selected half-row has key (r, c) pressed.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_col
      logic [7:0] col;
      for (gj = 0; gj < 8; gj++) begin : g_row
        assign col[gj] = matrix_q[gj*5 + gi];
      end
      assign kd_d[gi] = ~|(col & ~addr_hi);
    end
  endgenerate

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      matrix_q    <= '0;
      ctrl_q      <= 1'b0;
      alt_q       <= 1'b0;
      del_q       <= 1'b0;
      key_reset_q <= 1'b0;
      key_magic_q <= 1'b0;
      kd_q        <= 5'b11111;
`ifdef PS2_KEMPSTON_EN
      kemp_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      matrix_q    <= matrix_d;
      ctrl_q      <= ctrl_d;
      alt_q       <= alt_d;
      del_q       <= del_d;
      key_reset_q <= key_reset_d;
      key_magic_q <= key_magic_d;
      kd_q        <= kd_d;
`ifdef PS2_KEMPSTON_EN
      kemp_q      <= kemp_d;
`endif
    end
  end

  assign kd        = kd_q;
  assign key_reset = key_reset_q;
  assign key_magic = key_magic_q;
`ifdef PS2_KEMPSTON_EN
  assign kempston_data = {3'b000, kemp_q};
`endif

endmodule

// File: tb/tb_ps2_keyboard.sv
`timescale 1ns/1ps
module tb_ps2_keyboard;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] addr_hi = 8'hFF;
  logic [4:0] kd;
  logic       key_reset;
  logic       key_magic;
`ifdef PS2_KEMPSTON_EN
  logic [7:0] kempston_data;
`endif

  always #18 clk28 = ~clk28;

  ps2_keyboard dut (
    .clk28    (clk28),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .addr_hi  (addr_hi),
    .kd       (kd),
    .key_reset(key_reset),
    .key_magic(key_magic)
`ifdef PS2_KEMPSTON_EN
    ,
    .kempston_data(kempston_data)
`endif
  );

  int checks = 0;
  int errors = 0;
  int reset_pulses = 0;
  int magic_pulses = 0;

  always @(negedge clk28) begin
    if (key_reset === 1'b1) reset_pulses++;
    if (key_magic === 1'b1) magic_pulses++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (10) @(posedge clk28);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk28);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk28);
  endtask

  // Sends the first nbits bits of a frame; bad_par flips the parity bit.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    repeat (5) @(posedge clk28);
    $display("tx byte %02h bad_par=%0d bits=%0d", b, bad_par, nbits);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic read_kd(input logic [7:0] a, output logic [4:0] v);
    @(negedge clk28);
    addr_hi = a;
    repeat (2) @(posedge clk28);
    @(negedge clk28);
    v = kd;
  endtask

  typedef struct {
    logic       send;
    logic [7:0] code;
    logic       bad;
    logic [7:0] addr;
    logic [4:0] kd;
    string      name;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [4:0] v;
    int base;

    vecs[0]  = '{1'b1, 8'h1C, 1'b0, 8'hFD, 5'b11110, "a_make"};
    vecs[1]  = '{1'b1, 8'hF0, 1'b0, 8'hFD, 5'b11110, "f0_prefix_only"};
    vecs[2]  = '{1'b1, 8'h1C, 1'b0, 8'hFD, 5'b11111, "a_break"};
    vecs[3]  = '{1'b1, 8'h66, 1'b0, 8'hEE, 5'b11110, "bksp_two_rows"};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'hFE, 5'b11110, "bksp_caps"};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'hEF, 5'b11110, "bksp_zero"};
    vecs[6]  = '{1'b1, 8'hF0, 1'b0, 8'hFF, 5'b11111, "no_row_selected"};
    vecs[7]  = '{1'b1, 8'h66, 1'b0, 8'hEE, 5'b11111, "bksp_break"};
    vecs[8]  = '{1'b1, 8'h1A, 1'b1, 8'hFE, 5'b11111, "bad_parity_dropped"};
    vecs[9]  = '{1'b1, 8'hF0, 1'b1, 8'hFE, 5'b11111, "bad_parity_f0"};
    vecs[10] = '{1'b1, 8'h1A, 1'b0, 8'hFE, 5'b11101, "z_make_not_break"};
    vecs[11] = '{1'b1, 8'h15, 1'b0, 8'hFB, 5'b11110, "q_make"};
    vecs[12] = '{1'b1, 8'h24, 1'b0, 8'hFB, 5'b11010, "q_e_same_row"};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 5'b11000, "all_rows_and"};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 8'hFF, 5'b11111, "ff_reads_ones"};
    vecs[15] = '{1'b1, 8'hAA, 1'b0, 8'h00, 5'b11111, "bat_clears"};

    // Reset state
    addr_hi = 8'h00;
    repeat (5) @(posedge clk28);
    @(negedge clk28);
    check("reset_kd", {27'd0, kd}, 32'h1F);
    rst_n = 1'b1;
    repeat (5) @(posedge clk28);
    @(negedge clk28);
    check("reset_kd_released", {27'd0, kd}, 32'h1F);
    check("reset_key_reset", {31'd0, key_reset}, 32'd0);
    check("reset_key_magic", {31'd0, key_magic}, 32'd0);
`ifdef PS2_KEMPSTON_EN
    check("reset_kempston", {24'd0, kempston_data}, 32'd0);
`endif

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].send) send_frame(vecs[i].code, vecs[i].bad, 11);
      read_kd(vecs[i].addr, v);
      check(vecs[i].name, {27'd0, v}, {27'd0, vecs[i].kd});
    end

    // Cursor right (E0 74)
    send(8'hE0);
    send(8'h74);
`ifdef PS2_KEMPSTON_EN
    @(negedge clk28);
    check("kemp_right", {24'd0, kempston_data}, 32'h01);
    read_kd(8'h00, v);
    check("kemp_matrix_untouched", {27'd0, v}, 32'h1F);
`else
    read_kd(8'hEE, v);
    check("arrow_right_caps8", {27'd0, v}, 32'h1A);
`endif
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
`ifdef PS2_KEMPSTON_EN
    @(negedge clk28);
    check("kemp_right_break", {24'd0, kempston_data}, 32'h00);
`else
    read_kd(8'hEE, v);
    check("arrow_right_break", {27'd0, v}, 32'h1F);
`endif

    // Delete alone must not request a reset
    base = reset_pulses;
    send(8'hE0);
    send(8'h71);
    repeat (5) @(posedge clk28);
    check("del_alone_no_reset", reset_pulses - base, 32'd0);
    send(8'hE0);
    send(8'hF0);
    send(8'h71);

    // Ctrl + Alt + Del
    send(8'h14);
    send(8'h11);
    send(8'hE0);
    base = reset_pulses;
    send(8'h71);
    repeat (5) @(posedge clk28);
    check("chord_reset_one_cycle", reset_pulses - base, 32'd1);
    read_kd(8'h7F, v);
    check("ctrl_is_sym", {27'd0, v}, 32'h1D);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    send(8'h11);
    send(8'hE0);
    send(8'hF0);
    send(8'h71);

    // F11 magic: make pulses once, break does not
    base = magic_pulses;
    send(8'h78);
    repeat (5) @(posedge clk28);
    check("magic_one_cycle", magic_pulses - base, 32'd1);
    send(8'hF0);
    send(8'h78);
    repeat (5) @(posedge clk28);
    check("magic_break_silent", magic_pulses - base, 32'd1);

    // Pause sequence swallowed, then decoder back in IDLE
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    read_kd(8'h7F, v);
    check("pause_swallowed", {27'd0, v}, 32'h1F);
    send(8'h1C);
    read_kd(8'hFD, v);
    check("after_pause_a_make", {27'd0, v}, 32'h1E);
    send(8'hF0);
    send(8'h1C);

    // Partial frame abandoned by timeout
    send_frame(8'h29, 1'b0, 6);
    repeat (5000) @(posedge clk28);
    send(8'h29);
    read_kd(8'h7F, v);
    check("timeout_then_space", {27'd0, v}, 32'h1E);

    // Reset mid-frame with A and SPACE held
    send(8'h1C);
    send_frame(8'h1B, 1'b0, 5);
    @(negedge clk28);
    rst_n = 1'b0;
    addr_hi = 8'h00;
    repeat (3) @(posedge clk28);
    @(negedge clk28);
    check("midframe_rst_kd", {27'd0, kd}, 32'h1F);
    check("midframe_rst_key_reset", {31'd0, key_reset}, 32'd0);
`ifdef PS2_KEMPSTON_EN
    check("midframe_rst_kempston", {24'd0, kempston_data}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (3) @(posedge clk28);
    send(8'h1B);
    read_kd(8'hFD, v);
    check("rst_restart_s_only", {27'd0, v}, 32'h1D);
    read_kd(8'h7F, v);
    check("rst_space_cleared", {27'd0, v}, 32'h1F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
